mac_accumulator_16bit: RTL and testbench



---
 rtl/mac_accumulator_16bit.sv | 139 +++++++++++++
 tb/tb_mac_accumulator_16bit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator_16bit.sv
// Block accumulator: sums BLOCK_LEN unsigned 16-bit terms through one Kogge-Stone adder.
// Optional MAC_ACC_SAT_EN saturates the block sum at 16'hFFFF once a carry-out has occurred.

module kogge_stone_16bitt (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] s,
   output logic        cout
);
   logic [15:0] g0;
   logic [15:0] p0;
   logic [15:0] carry;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_bit
         assign p0[gi] = a[gi] ^ b[gi];
         if (gi == 0) begin : g_lsb
            // Fold the carry-in into bit 0 so the prefix tree needs no extra column.
            assign g0[gi] = (a[gi] & b[gi]) | (p0[gi] & cin);
         end else begin : g_oth
            assign g0[gi] = a[gi] & b[gi];
         end
      end
   endgenerate

   always_comb begin : prefix
      logic [15:0] g_cur;
      logic [15:0] p_cur;
      logic [15:0] g_nxt;
      logic [15:0] p_nxt;
      g_cur = g0;
      p_cur = p0;
      g_nxt = g0;
      p_nxt = p0;
      for (int lv = 0; lv < 4; lv++) begin
         g_nxt = g_cur;
         p_nxt = p_cur;
         for (int b_i = 0; b_i < 16; b_i++) begin
            if (b_i >= (1 << lv)) begin
               g_nxt[b_i] = g_cur[b_i] | (p_cur[b_i] & g_cur[b_i - (1 << lv)]);
               p_nxt[b_i] = p_cur[b_i] & p_cur[b_i - (1 << lv)];
            end
         end
         g_cur = g_nxt;
         p_cur = p_nxt;
      end
      carry = g_cur;
   end

   assign s    = p0 ^ {carry[14:0], cin};
   assign cout = carry[15];
endmodule

module mac_accumulator_16bit #(
   parameter int BLOCK_LEN = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_ovf
);
   typedef enum logic {ST_ACC, ST_DONE} state_t;

   localparam logic [7:0] LAST_CNT = 8'(BLOCK_LEN - 1);

   state_t      state_reg;
   logic [15:0] acc_reg;
   logic        ovf_reg;
   logic [7:0]  cnt_reg;
   logic [15:0] sum;
   logic        sum_cout;
   logic [15:0] acc_next;

   kogge_stone_16bitt u_adder (
      .a    (acc_reg),
      .b    (in_data),
      .cin  (1'b0),
      .s    (sum),
      .cout (sum_cout)
   );

`ifdef MAC_ACC_SAT_EN
   assign acc_next = (sum_cout | ovf_reg) ? 16'hFFFF : sum;
`else
   assign acc_next = sum;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_ACC;
         acc_reg   <= '0;
         ovf_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else if (clr) begin
         state_reg <= ST_ACC;
         acc_reg   <= '0;
         ovf_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            ST_ACC: begin
               if (in_valid) begin
                  acc_reg <= acc_next;
                  ovf_reg <= ovf_reg | sum_cout;
                  if (cnt_reg == LAST_CNT) begin
                     // Count restarts here so it never exceeds BLOCK_LEN-1.
                     cnt_reg   <= '0;
                     state_reg <= ST_DONE;
                  end else begin
                     cnt_reg <= cnt_reg + 8'd1;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  acc_reg   <= '0;
                  ovf_reg   <= 1'b0;
                  cnt_reg   <= '0;
                  state_reg <= ST_ACC;
               end
            end
            default: state_reg <= ST_ACC;
         endcase
      end
   end

   assign in_ready  = (state_reg == ST_ACC);
   assign out_valid = (state_reg == ST_DONE);
   assign out_data  = acc_reg;
   assign out_ovf   = ovf_reg;
endmodule

// File: tb/tb_mac_accumulator_16bit.sv
// Randomized and directed bench for mac_accumulator_16bit (BLOCK_LEN = 4) against an integer-sum model.

module tb_mac_accumulator_16bit;
   localparam int BL = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_ovf;

   int checks = 0;
   int errors = 0;

   // Model: block is just a running integer sum and a term count.
   int m_sum = 0;
   int m_cnt = 0;
   bit m_pending = 1'b0;

   mac_accumulator_16bit #(.BLOCK_LEN(BL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_data(input int s);
      logic [31:0] sv;
      sv = s;
`ifdef MAC_ACC_SAT_EN
      if (s > 65535) return 16'hFFFF;
`endif
      return sv[15:0];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sum     <= 0;
         m_cnt     <= 0;
         m_pending <= 1'b0;
      end else if (clr) begin
         m_sum     <= 0;
         m_cnt     <= 0;
         m_pending <= 1'b0;
      end else if (m_pending) begin
         if (out_ready) begin
            m_sum     <= 0;
            m_cnt     <= 0;
            m_pending <= 1'b0;
         end
      end else if (in_valid) begin
         m_sum <= m_sum + int'(in_data);
         m_cnt <= m_cnt + 1;
         if (m_cnt + 1 == BL) m_pending <= 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("in_ready", in_ready, !m_pending);
      chk("out_valid", out_valid, m_pending);
      if (m_pending) begin
         chk("out_data", out_data, exp_data(m_sum));
         chk("out_ovf", out_ovf, m_sum > 65535);
         if (out_ready && rst_n && !clr)
            $display("result data=%h ovf=%b", out_data, out_ovf);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 50) begin
         cyc();
         n++;
      end
      chk("push_ready", in_ready, 1'b1);
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic result(input string name, input logic [15:0] d, input logic o);
      chk({name, "_valid"}, out_valid, 1'b1);
      chk({name, "_data"}, out_data, d);
      chk({name, "_ovf"}, out_ovf, o);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 16'd0);
      chk("rst_in_ready", in_ready, 1'b1);

      // Basic sum
      out_ready = 1'b1;
      push(16'd10); push(16'd13); push(16'd1); push(16'd2);
      result("basic", 16'd26, 1'b0);
      cyc();
      chk("basic_ready_back", in_ready, 1'b1);

      // Overflow
      push(16'hFFFF); push(16'h0001); push(16'h0003); push(16'h0000);
`ifdef MAC_ACC_SAT_EN
      result("ovf", 16'hFFFF, 1'b1);
`else
      result("ovf", 16'h0003, 1'b1);
`endif
      cyc();

      // Backpressure
      out_ready = 1'b0;
      repeat (BL) push(16'd1);
      for (int i = 0; i < 5; i++) begin
         result("bp_hold", 16'd4, 1'b0);
         chk("bp_in_ready", in_ready, 1'b0);
         cyc();
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      repeat (BL) push(16'd2);
      result("bp_next", 16'd8, 1'b0);
      out_ready = 1'b1;
      cyc();

      // Bubbles
      for (int i = 0; i < BL; i++) begin
         push(16'd5);
         if (i < BL - 1) begin
            chk("bub_no_valid", out_valid, 1'b0);
            cyc();
         end
      end
      result("bubbles", 16'd20, 1'b0);
      cyc();

      // Clear drops the concurrent term
      push(16'd7); push(16'd7);
      clr = 1'b1; in_valid = 1'b1; in_data = 16'd9;
      cyc();
      clr = 1'b0; in_valid = 1'b0;
      push(16'd1); push(16'd2); push(16'd3); push(16'd4);
      result("clear", 16'd10, 1'b0);
      cyc();

      // Reset mid-block
      push(16'd3); push(16'd3);
      rst_n = 1'b0;
      cyc();
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_data", out_data, 16'd0);
      chk("mid_rst_ovf", out_ovf, 1'b0);
      chk("mid_rst_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      cyc();
      repeat (BL) push(16'd1);
      result("post_rst", 16'd4, 1'b0);
      cyc();

      // Random traffic checked by the per-cycle model compare
      for (int i = 0; i < 2000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
         out_ready = ($urandom_range(0, 2) != 0);
         clr       = ($urandom_range(0, 39) == 0);
         cyc();
      end
      in_valid = 1'b0;
      clr = 1'b0;
      out_ready = 1'b1;
      repeat (3) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
